// File: rtl/block_loader.sv
// Byte-stream block assembler: gathers one K_SMALL or K_LARGE code block into a parallel
// register and holds it with blk_valid until the consumer acknowledges it.
module block_loader #(
  parameter int K_LARGE = 6144,
  parameter int K_SMALL = 1056,
  parameter int BYTE_W  = 8
) (
  input  logic               CLOCK_50,
  input  logic               KEY_0,
  input  logic               flush,
  input  logic               k_size_6144,
  input  logic [BYTE_W-1:0]  byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic [K_LARGE-1:0] blk_data,
  output logic               blk_k_6144,
  output logic               blk_valid,
  input  logic               blk_ack,
  output logic [9:0]         byte_count
);

  localparam int CNT_W   = 10;
  localparam int BIT_W   = $clog2(K_LARGE);
  localparam int N_LARGE = K_LARGE / BYTE_W;
  localparam int N_SMALL = K_SMALL / BYTE_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FULL
  } state_t;

  state_t             r_state;
  logic [K_LARGE-1:0] r_blk_data;
  logic               r_blk_k_6144;
  logic [CNT_W-1:0]   r_byte_count;
  logic               r_byte_ready;
  logic               r_blk_valid;

  logic               w_xfer;
  logic               w_last;
  logic [CNT_W-1:0]   w_last_idx;
  logic [BIT_W-1:0]   w_bit_base;

  assign w_xfer     = byte_valid & r_byte_ready;
  assign w_last_idx = r_blk_k_6144 ? CNT_W'(N_LARGE - 1) : CNT_W'(N_SMALL - 1);
  assign w_last     = (r_byte_count == w_last_idx);
  assign w_bit_base = BIT_W'(r_byte_count) * BIT_W'(BYTE_W);

  // NOTE: the whole block register is reset because a cleared blk_data after reset/flush is
  // part of the observable contract; a RAM-style store without reset would not honour it.
  always_ff @(posedge CLOCK_50 or negedge KEY_0) begin
    if (!KEY_0) begin
      r_state      <= S_IDLE;
      r_blk_data   <= '0;
      r_blk_k_6144 <= 1'b0;
      r_byte_count <= '0;
      r_byte_ready <= 1'b1;
      r_blk_valid  <= 1'b0;
    end else if (flush) begin
      r_state      <= S_IDLE;
      r_blk_data   <= '0;
      r_blk_k_6144 <= 1'b0;
      r_byte_count <= '0;
      r_byte_ready <= 1'b1;
      r_blk_valid  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values, so
      // w_last and w_bit_base below see the count before this edge's increment.
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_blk_data   <= {{(K_LARGE - BYTE_W){1'b0}}, byte_in};
            r_blk_k_6144 <= k_size_6144;
            r_byte_count <= CNT_W'(1);
            r_state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            r_blk_data[w_bit_base +: BYTE_W] <= byte_in;
            r_byte_count <= r_byte_count + CNT_W'(1);
            if (w_last) begin
              r_state      <= S_FULL;
              r_byte_ready <= 1'b0;
              r_blk_valid  <= 1'b1;
            end
          end
        end
        S_FULL: begin
          if (blk_ack) begin
            r_state      <= S_IDLE;
            r_byte_count <= '0;
            r_byte_ready <= 1'b1;
            r_blk_valid  <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_byte_count <= '0;
          r_byte_ready <= 1'b1;
          r_blk_valid  <= 1'b0;
        end
      endcase
    end
  end

  // Ready is forced low while reset is held so no byte is lost to a reset in progress.
  assign byte_ready = r_byte_ready & KEY_0;
  assign blk_data   = r_blk_data;
  assign blk_k_6144 = r_blk_k_6144;
  assign blk_valid  = r_blk_valid;
  assign byte_count = r_byte_count;

  a_ready_valid_exclusive : assert property (
    @(posedge CLOCK_50) disable iff (!KEY_0) !(r_byte_ready && r_blk_valid));

  a_count_bound : assert property (
    @(posedge CLOCK_50) disable iff (!KEY_0) r_byte_count <= CNT_W'(N_LARGE));

endmodule
